// File: rtl/fifo_tx_pkg.sv
// fifo_tx_pkg: FSM state type and serial line levels shared by fifo_serial_tx.
package fifo_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic TX_IDLE   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: bit-period counter running 0..CLKS_PER_BIT-1.
// tick marks the last cycle of a bit period; pre_tick marks the cycle before it,
// which lets the parent register pulses that must land on the last cycle.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick,
    output logic pre_tick
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: held at zero while cleared, otherwise wraps at the end of each bit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick     = !clr && (cnt_q == LAST);
    assign pre_tick = !clr && (cnt_q == PRE);

endmodule

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: drains the byte FIFO one entry at a time and serialises each byte
// as start, DATA_W data bits LSB-first, optional even parity, stop.
// Build option: define FIFO_TX_PARITY_EN to insert the even-parity bit (11-bit frame).
// All pin-facing outputs come straight from flops; they are computed from the next state.
module fifo_serial_tx
    import fifo_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              tx_q, tx_d;
    logic              fifo_rd_q, fifo_rd_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
`ifdef FIFO_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic baud_clr;
    logic baud_tick;
    logic baud_pre_tick;

    // Bit timing restarts from zero on the first START cycle.
    assign baud_clr = (state_q == IDLE) || (state_q == READ) || (state_q == LOAD);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clr      (baud_clr),
        .tick     (baud_tick),
        .pre_tick (baud_pre_tick)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
`ifdef FIFO_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_en && !fifo_empty) state_d = READ;
            end
            READ: begin
                state_d = LOAD;
            end
            LOAD: begin
                // FIFO output is valid the cycle after the read strobe.
                shreg_d = fifo_data;
`ifdef FIFO_TX_PARITY_EN
                parity_d = ^fifo_data;
`endif
                state_d = START;
            end
            START: begin
                if (baud_tick) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef FIFO_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shreg_d   = shreg_q >> 1;
                    end
                end
            end
`ifdef FIFO_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) state_d = STOP;
            end
`endif
            STOP: begin
                // Back-to-back frames go straight to READ; the line stays at the
                // stop level through READ and LOAD.
                if (baud_tick) state_d = (tx_en && !fifo_empty) ? READ : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        fifo_rd_d    = (state_d == READ);
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_q == STOP) && baud_pre_tick;

        case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = shreg_d[0];
`ifdef FIFO_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            STOP:    tx_d = STOP_BIT;
            default: tx_d = TX_IDLE;
        endcase
    end

    // State, datapath and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            tx_q         <= TX_IDLE;
            fifo_rd_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef FIFO_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_q         <= tx_d;
            fifo_rd_q    <= fifo_rd_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
`ifdef FIFO_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign tx         = tx_q;
    assign fifo_rd    = fifo_rd_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb_fifo_serial_tx: self-checking bench for fifo_serial_tx with a small FIFO model.
// Expected line waveforms are built from the frame rules (start, LSB-first data,
// optional even parity, stop, each CLKS_PER_BIT cycles). Honours FIFO_TX_PARITY_EN.
module tb_fifo_serial_tx;
    localparam int N = 4;
`ifdef FIFO_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * N;
    localparam logic [63:0] FD_MASK   = 64'd1 << (FRAME - 1);
    localparam logic [63:0] BUSY_MASK = (64'd1 << FRAME) - 64'd1;

    logic       clk;
    logic       reset;
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd;
    logic       tx;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    // FIFO model
    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    // Monitors
    int cyc = 0;
    int rd_cnt = 0;
    int fd_cnt = 0;
    int bad_rd = 0;
    int last_rd_cyc = -100;

    // Capture results
    logic [63:0] cap_tx, cap_fd, cap_busy;
    int          cap_start_cyc;
    bit          cap_ok;

    fifo_serial_tx #(
        .DATA_W(8),
        .CLKS_PER_BIT(N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial fifo_data = 8'h00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd === 1'b1 && !fifo_empty) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    always @(negedge clk) begin
        if (fifo_rd === 1'b1) begin
            rd_cnt      <= rd_cnt + 1;
            last_rd_cyc <= cyc;
            if (fifo_empty) bad_rd <= bad_rd + 1;
        end
        if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    // Expected line level for each cycle of a frame carrying byte b.
    function automatic logic [63:0] exp_wave(input logic [7:0] b);
        logic [63:0] w;
        int          bi;
        w = '0;
        for (int k = 0; k < FRAME; k++) begin
            bi = k / N;
            if (bi == 0)              w[k] = 1'b0;
            else if (bi <= 8)         w[k] = b[bi-1];
            else if (bi == NBITS - 1) w[k] = 1'b1;
            else                      w[k] = ^b;
        end
        return w;
    endfunction

    // Wait (bounded) for a start bit, then record one frame's worth of outputs.
    task automatic capture_frame(input int budget);
        cap_ok = 1'b0;
        cap_tx = '0;
        cap_fd = '0;
        cap_busy = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                cap_ok = 1'b1;
                break;
            end
        end
        if (cap_ok) begin
            cap_start_cyc = cyc;
            cap_tx[0] = tx;
            cap_fd[0] = frame_done;
            cap_busy[0] = busy;
            for (int k = 1; k < FRAME; k++) begin
                @(negedge clk);
                cap_tx[k] = tx;
                cap_fd[k] = frame_done;
                cap_busy[k] = busy;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tx_en = 1'b0;
        push(8'h5A);
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", fifo_rd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b want 0", frame_done); end
        #7 reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1 || rd_cnt != 0) begin errors++; $display("FAIL reset_idle: tx %b rd %0d want 1 0", tx, rd_cnt); end
    endtask

    task automatic test_single;
        int rd0, fd0;
        @(negedge clk);
        wr_ptr = rd_ptr;
        rd0 = rd_cnt;
        fd0 = fd_cnt;
        push(8'hAA);
        tx_en = 1'b1;
        capture_frame(20);
        checks++;
        if (!cap_ok) begin
            errors++; $display("FAIL single_start: no start bit within 20 cycles");
        end else begin
            $display("frame byte=aa start_cyc=%0d wave=%h", cap_start_cyc, cap_tx);
            checks++; if (cap_tx !== exp_wave(8'hAA)) begin errors++; $display("FAIL single_wave: got %h want %h", cap_tx, exp_wave(8'hAA)); end
            checks++; if (cap_fd !== FD_MASK) begin errors++; $display("FAIL single_fd: got %h want %h", cap_fd, FD_MASK); end
            checks++; if (cap_busy !== BUSY_MASK) begin errors++; $display("FAIL single_busy: got %h want %h", cap_busy, BUSY_MASK); end
            checks++; if (cap_start_cyc - last_rd_cyc != 2) begin errors++; $display("FAIL single_latency: got %0d want 2", cap_start_cyc - last_rd_cyc); end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL single_after: busy %b tx %b want 0 1", busy, tx); end
        checks++; if (rd_cnt - rd0 != 1) begin errors++; $display("FAIL single_rdcount: got %0d want 1", rd_cnt - rd0); end
        checks++; if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL single_fdcount: got %0d want 1", fd_cnt - fd0); end
    endtask

    // A queued burst must go out as back-to-back frames separated only by READ+LOAD.
    task automatic run_burst(input logic [7:0] bytes_in [4], input int n, input string tag);
        int rd0, prev_start;
        rd0 = rd_cnt;
        prev_start = 0;
        @(negedge clk);
        for (int i = 0; i < n; i++) push(bytes_in[i]);
        tx_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            capture_frame(3 * N + 4);
            checks++;
            if (!cap_ok) begin
                errors++; $display("FAIL %s_start%0d: no start bit", tag, i);
                break;
            end
            $display("frame %s byte=%h start_cyc=%0d wave=%h", tag, bytes_in[i], cap_start_cyc, cap_tx);
            checks++; if (cap_tx !== exp_wave(bytes_in[i])) begin errors++; $display("FAIL %s_wave%0d: got %h want %h", tag, i, cap_tx, exp_wave(bytes_in[i])); end
            if (i > 0) begin
                checks++; if (cap_start_cyc - prev_start != FRAME + 2) begin errors++; $display("FAIL %s_gap%0d: got %0d want %0d", tag, i, cap_start_cyc - prev_start, FRAME + 2); end
            end
            prev_start = cap_start_cyc;
        end
        @(negedge clk);
        checks++; if (rd_cnt - rd0 != n) begin errors++; $display("FAIL %s_rdcount: got %0d want %0d", tag, rd_cnt - rd0, n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle_busy: got %b want 0", tag, busy); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] b [4];
        b[0] = 8'hAA; b[1] = 8'hCC; b[2] = 8'h00; b[3] = 8'h00;
        run_burst(b, 2, "b2b");
    endtask

    task automatic test_random;
        logic [7:0] b [4];
        int n;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
            run_burst(b, n, "rand");
        end
    endtask

    task automatic test_tx_en_gate;
        int  rd0, raise_cyc;
        bit  quiet;
        @(negedge clk);
        tx_en = 1'b0;
        rd0 = rd_cnt;
        push(8'h3C);
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || fifo_rd !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet || rd_cnt != rd0) begin errors++; $display("FAIL gate_hold: quiet %b rd %0d want 1 0", quiet, rd_cnt - rd0); end
        raise_cyc = cyc;
        tx_en = 1'b1;
        capture_frame(10);
        checks++;
        if (!cap_ok) begin
            errors++; $display("FAIL gate_start: no start bit after tx_en");
        end else begin
            $display("frame gate byte=3c start_cyc=%0d wave=%h", cap_start_cyc, cap_tx);
            checks++; if (last_rd_cyc - raise_cyc != 1) begin errors++; $display("FAIL gate_rd_delay: got %0d want 1", last_rd_cyc - raise_cyc); end
            checks++; if (cap_start_cyc - raise_cyc != 3) begin errors++; $display("FAIL gate_start_delay: got %0d want 3", cap_start_cyc - raise_cyc); end
            checks++; if (cap_tx !== exp_wave(8'h3C)) begin errors++; $display("FAIL gate_wave: got %h want %h", cap_tx, exp_wave(8'h3C)); end
        end
        @(negedge clk);
    endtask

    task automatic test_tx_en_drop;
        int         rd0;
        bit         quiet;
        logic [7:0] b0, b1;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        @(negedge clk);
        rd0 = rd_cnt;
        push(b0);
        push(b1);
        tx_en = 1'b1;
        fork
            capture_frame(12);
            begin
                repeat (10) @(negedge clk);
                tx_en = 1'b0;
            end
        join
        checks++;
        if (!cap_ok) begin
            errors++; $display("FAIL drop_start: no start bit");
        end else begin
            $display("frame drop byte=%h start_cyc=%0d wave=%h", b0, cap_start_cyc, cap_tx);
            checks++; if (cap_tx !== exp_wave(b0)) begin errors++; $display("FAIL drop_wave: got %h want %h", cap_tx, exp_wave(b0)); end
        end
        quiet = 1'b1;
        repeat (3 * N) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet || rd_cnt - rd0 != 1) begin errors++; $display("FAIL drop_norestart: quiet %b rd %0d want 1 1", quiet, rd_cnt - rd0); end
        tx_en = 1'b1;
        capture_frame(10);
        checks++;
        if (!cap_ok) begin
            errors++; $display("FAIL drop_resume: no start bit");
        end else begin
            $display("frame resume byte=%h start_cyc=%0d wave=%h", b1, cap_start_cyc, cap_tx);
            checks++; if (cap_tx !== exp_wave(b1)) begin errors++; $display("FAIL drop_resume_wave: got %h want %h", cap_tx, exp_wave(b1)); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b;
        int         off, rd0;
        bit         ok, quiet;
        for (int c = 0; c < 2; c++) begin
            b   = (c == 0) ? 8'hCC : 8'($urandom);
            off = (c == 0) ? 17 : 2;
            @(negedge clk);
            wr_ptr = rd_ptr;
            push(b);
            tx_en = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (tx === 1'b0) begin ok = 1'b1; break; end
            end
            checks++;
            if (!ok) begin
                errors++; $display("FAIL rstmid_start%0d: no start bit", c);
            end else begin
                repeat (off) @(negedge clk);
                #2 reset = 1'b0;
                #1;
                $display("reset mid-frame byte=%h at frame cycle %0d", b, off);
                checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx%0d: got %b want 1", c, tx); end
                checks++; if (busy !== 1'b0 || fifo_rd !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_outs%0d: busy %b rd %b fd %b want 0 0 0", c, busy, fifo_rd, frame_done); end
                repeat (2) @(negedge clk);
                #2 reset = 1'b1;
                rd0 = rd_cnt;
                quiet = 1'b1;
                repeat (3 * N) begin
                    @(negedge clk);
                    if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
                end
                checks++; if (!quiet || rd_cnt != rd0) begin errors++; $display("FAIL rstmid_idle%0d: quiet %b rd %0d want 1 0", c, quiet, rd_cnt - rd0); end
            end
        end
    endtask

`ifdef FIFO_TX_PARITY_EN
    task automatic test_parity;
        logic [7:0] b [4];
        b[0] = 8'h07; b[1] = 8'h03; b[2] = 8'h00; b[3] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            push(b[i]);
            tx_en = 1'b1;
            capture_frame(10);
            checks++;
            if (!cap_ok) begin
                errors++; $display("FAIL parity_start%0d: no start bit", i);
            end else begin
                $display("frame parity byte=%h start_cyc=%0d wave=%h", b[i], cap_start_cyc, cap_tx);
                checks++; if (cap_tx[9*N+1] !== ((i == 0) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL parity_bit%0d: got %b want %b", i, cap_tx[9*N+1], (i == 0) ? 1'b1 : 1'b0); end
                checks++; if (cap_tx !== exp_wave(b[i])) begin errors++; $display("FAIL parity_wave%0d: got %h want %h", i, cap_tx, exp_wave(b[i])); end
                checks++; if (cap_fd !== FD_MASK) begin errors++; $display("FAIL parity_fd%0d: got %h want %h", i, cap_fd, FD_MASK); end
            end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_tx_en_gate();
        test_tx_en_drop();
        test_reset_mid_frame();
        test_random();
`ifdef FIFO_TX_PARITY_EN
        test_parity();
`endif
        @(negedge clk);
        checks++; if (bad_rd != 0) begin errors++; $display("FAIL rd_when_empty: got %0d want 0", bad_rd); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
